// File: rtl/scm_arb_pkg.sv
// Shared constants and types for the SCM port arbiter.
// Port indices follow the macro's physical ports: A (R/W), scm0 (R/W), scm1 (read-only).
package scm_arb_pkg;

    localparam int NUM_PORTS = 3;
    localparam int PORT_A    = 0;
    localparam int PORT_S0   = 1;
    localparam int PORT_S1   = 2;

    // Geometry of the 2048x32 latch-based macro.
    localparam int SCM_ADDR_WIDTH = 11;
    localparam int SCM_DATA_WIDTH = 32;
    localparam int SCM_BE_WIDTH   = SCM_DATA_WIDTH / 8;

    typedef logic [1:0] port_sel_t;

    typedef struct packed {
        logic                      cen;
        logic                      wen;
        logic [SCM_BE_WIDTH-1:0]   be;
        logic [SCM_ADDR_WIDTH-1:0] addr;
        logic [SCM_DATA_WIDTH-1:0] wdata;
    } scm_port_t;

    localparam scm_port_t SCM_PORT_IDLE = '{cen: 1'b1, wen: 1'b1, be: '0, addr: '0, wdata: '0};

endpackage

// File: rtl/scm_arb_alloc.sv
// Combinational round-robin scan that maps up to three requests onto the SCM ports,
// with same-word hazard blocking against requests granted earlier in the same scan.
module scm_arb_alloc
    import scm_arb_pkg::*;
#(
    parameter int NB_MASTERS = 4,
    parameter int ADDR_WIDTH = 11,
    parameter int IDX_WIDTH  = $clog2(NB_MASTERS)
) (
    input  logic [NB_MASTERS-1:0]            req,
    input  logic [NB_MASTERS-1:0]            wen,
    input  logic [NB_MASTERS*ADDR_WIDTH-1:0] add,
    input  logic [IDX_WIDTH-1:0]             rr_q,
    output logic [NB_MASTERS-1:0]            gnt,
    output logic [2*NB_MASTERS-1:0]          port_sel,
    output logic [NUM_PORTS*IDX_WIDTH-1:0]   port_master,
    output logic [NUM_PORTS-1:0]             port_valid,
    output logic [IDX_WIDTH-1:0]             last_idx
);

    logic [ADDR_WIDTH-1:0] port_addr [NUM_PORTS];
    logic [NUM_PORTS-1:0]  port_wr;
    logic [IDX_WIDTH:0]    scan;
    logic [IDX_WIDTH-1:0]  idx;
    logic [ADDR_WIDTH-1:0] addr_m;
    logic                  hazard;
    int                    sel;

    always_comb begin
        gnt         = '0;
        port_sel    = '0;
        port_master = '0;
        port_valid  = '0;
        last_idx    = '0;
        port_wr     = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            port_addr[p] = '0;
        end
        scan   = '0;
        idx    = '0;
        addr_m = '0;
        hazard = 1'b0;
        sel    = -1;

        for (int k = 0; k < NB_MASTERS; k++) begin
            scan = {1'b0, rr_q} + (IDX_WIDTH+1)'(k);
            if (scan >= (IDX_WIDTH+1)'(NB_MASTERS)) begin
                scan = scan - (IDX_WIDTH+1)'(NB_MASTERS);
            end
            idx    = scan[IDX_WIDTH-1:0];
            addr_m = add[idx*ADDR_WIDTH +: ADDR_WIDTH];

            // Reads only collide with granted writes; writes collide with anything.
            hazard = 1'b0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (port_valid[p] && (port_addr[p] == addr_m) && (port_wr[p] || !wen[idx])) begin
                    hazard = 1'b1;
                end
            end

            sel = -1;
            if (req[idx] && !hazard) begin
                if (!wen[idx]) begin
                    if (!port_valid[PORT_A])       sel = PORT_A;
                    else if (!port_valid[PORT_S0]) sel = PORT_S0;
                end else begin
                    if (!port_valid[PORT_S1])      sel = PORT_S1;
                    else if (!port_valid[PORT_S0]) sel = PORT_S0;
                    else if (!port_valid[PORT_A])  sel = PORT_A;
                end
            end

            if (sel >= 0) begin
                port_valid[sel]                         = 1'b1;
                port_wr[sel]                            = !wen[idx];
                port_addr[sel]                          = addr_m;
                port_master[sel*IDX_WIDTH +: IDX_WIDTH] = idx;
                gnt[idx]                                = 1'b1;
                port_sel[idx*2 +: 2]                    = port_sel_t'(sel);
                last_idx                                = idx;
            end
        end
    end

endmodule

// File: rtl/scm_port_arbiter.sv
// Shares the 3-read/2-write SCM macro among NB_MASTERS TCDM requesters:
// round-robin allocation, SCM port muxing, and a one-cycle read-response pipeline.
module scm_port_arbiter
    import scm_arb_pkg::*;
#(
    parameter int NB_MASTERS = 4,
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32
) (
    input  logic                              CLK,
    input  logic                              RSTN,
    input  logic [NB_MASTERS-1:0]             req_i,
    output logic [NB_MASTERS-1:0]             gnt_o,
    input  logic [NB_MASTERS*ADDR_WIDTH-1:0]  add_i,
    input  logic [NB_MASTERS-1:0]             wen_i,
    input  logic [NB_MASTERS*DATA_WIDTH/8-1:0] be_i,
    input  logic [NB_MASTERS*DATA_WIDTH-1:0]  wdata_i,
    output logic [NB_MASTERS-1:0]             r_valid_o,
    output logic [NB_MASTERS*DATA_WIDTH-1:0]  r_rdata_o,
    output logic                              CEN,
    output logic                              CEN_scm0,
    output logic                              CEN_scm1,
    output logic                              WEN,
    output logic                              WEN_scm0,
    output logic                              WEN_scm1,
    output logic [DATA_WIDTH/8-1:0]           BE,
    output logic [DATA_WIDTH/8-1:0]           BE_scm0,
    output logic [ADDR_WIDTH-1:0]             A,
    output logic [ADDR_WIDTH-1:0]             A_scm0,
    output logic [ADDR_WIDTH-1:0]             A_scm1,
    output logic [DATA_WIDTH-1:0]             D,
    output logic [DATA_WIDTH-1:0]             D_scm0,
    input  logic [DATA_WIDTH-1:0]             Q,
    input  logic [DATA_WIDTH-1:0]             Q_scm0,
    input  logic [DATA_WIDTH-1:0]             Q_scm1
);

    localparam int BE_WIDTH  = DATA_WIDTH / 8;
    localparam int IDX_WIDTH = $clog2(NB_MASTERS);

    // The port struct carries the macro's fixed geometry.
    if (ADDR_WIDTH != SCM_ADDR_WIDTH || DATA_WIDTH != SCM_DATA_WIDTH) begin : g_geom_check
        $error("scm_port_arbiter: ADDR_WIDTH/DATA_WIDTH must match the SCM macro geometry");
    end

    logic [NB_MASTERS-1:0]          req_g;
    logic [NB_MASTERS-1:0]          gnt;
    logic [2*NB_MASTERS-1:0]        port_sel;
    logic [NUM_PORTS*IDX_WIDTH-1:0] port_master;
    logic [NUM_PORTS-1:0]           port_valid;
    logic [IDX_WIDTH-1:0]           last_idx;
    logic [IDX_WIDTH-1:0]           rr_q;
    logic [IDX_WIDTH-1:0]           rr_d;
    logic [IDX_WIDTH:0]             rr_inc;

    logic [NB_MASTERS-1:0] resp_valid;
    logic [NB_MASTERS-1:0] resp_is_read;
    port_sel_t             resp_port [NB_MASTERS];

    logic [IDX_WIDTH-1:0] mst_a;
    logic [IDX_WIDTH-1:0] mst_s0;
    logic [IDX_WIDTH-1:0] mst_s1;
    scm_port_t            port_a;
    scm_port_t            port_s0;

    // Requests seen while reset is asserted never reach the allocator.
    assign req_g = req_i & {NB_MASTERS{RSTN}};

    scm_arb_alloc #(
        .NB_MASTERS (NB_MASTERS),
        .ADDR_WIDTH (ADDR_WIDTH),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_alloc (
        .req         (req_g),
        .wen         (wen_i),
        .add         (add_i),
        .rr_q        (rr_q),
        .gnt         (gnt),
        .port_sel    (port_sel),
        .port_master (port_master),
        .port_valid  (port_valid),
        .last_idx    (last_idx)
    );

    assign gnt_o = gnt;

    assign rr_inc = {1'b0, last_idx} + (IDX_WIDTH+1)'(1);
    assign rr_d   = (rr_inc >= (IDX_WIDTH+1)'(NB_MASTERS)) ? '0 : rr_inc[IDX_WIDTH-1:0];

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            rr_q <= '0;
        end else if (|gnt) begin
            rr_q <= rr_d;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            resp_valid   <= '0;
            resp_is_read <= '0;
            for (int m = 0; m < NB_MASTERS; m++) begin
                resp_port[m] <= '0;
            end
        end else begin
            resp_valid   <= gnt;
            resp_is_read <= gnt & wen_i;
            for (int m = 0; m < NB_MASTERS; m++) begin
                resp_port[m] <= port_sel[m*2 +: 2];
            end
        end
    end

    assign mst_a  = port_master[PORT_A*IDX_WIDTH  +: IDX_WIDTH];
    assign mst_s0 = port_master[PORT_S0*IDX_WIDTH +: IDX_WIDTH];
    assign mst_s1 = port_master[PORT_S1*IDX_WIDTH +: IDX_WIDTH];

    always_comb begin
        port_a = SCM_PORT_IDLE;
        if (port_valid[PORT_A]) begin
            port_a.cen   = 1'b0;
            port_a.wen   = wen_i[mst_a];
            port_a.be    = be_i[mst_a*BE_WIDTH +: BE_WIDTH];
            port_a.addr  = add_i[mst_a*ADDR_WIDTH +: ADDR_WIDTH];
            port_a.wdata = wdata_i[mst_a*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        port_s0 = SCM_PORT_IDLE;
        if (port_valid[PORT_S0]) begin
            port_s0.cen   = 1'b0;
            port_s0.wen   = wen_i[mst_s0];
            port_s0.be    = be_i[mst_s0*BE_WIDTH +: BE_WIDTH];
            port_s0.addr  = add_i[mst_s0*ADDR_WIDTH +: ADDR_WIDTH];
            port_s0.wdata = wdata_i[mst_s0*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign CEN = port_a.cen;
    assign WEN = port_a.wen;
    assign BE  = port_a.be;
    assign A   = port_a.addr;
    assign D   = port_a.wdata;

    assign CEN_scm0 = port_s0.cen;
    assign WEN_scm0 = port_s0.wen;
    assign BE_scm0  = port_s0.be;
    assign A_scm0   = port_s0.addr;
    assign D_scm0   = port_s0.wdata;

    // scm1 is read-only, so only enable, read strobe and address exist.
    assign CEN_scm1 = !port_valid[PORT_S1];
    assign WEN_scm1 = port_valid[PORT_S1] ? wen_i[mst_s1] : 1'b1;
    assign A_scm1   = port_valid[PORT_S1] ? add_i[mst_s1*ADDR_WIDTH +: ADDR_WIDTH] : '0;

    assign r_valid_o = resp_valid;

    always_comb begin
        r_rdata_o = '0;
        for (int m = 0; m < NB_MASTERS; m++) begin
            if (resp_valid[m] && resp_is_read[m]) begin
                if (resp_port[m] == port_sel_t'(PORT_A)) begin
                    r_rdata_o[m*DATA_WIDTH +: DATA_WIDTH] = Q;
                end else if (resp_port[m] == port_sel_t'(PORT_S0)) begin
                    r_rdata_o[m*DATA_WIDTH +: DATA_WIDTH] = Q_scm0;
                end else if (resp_port[m] == port_sel_t'(PORT_S1)) begin
                    r_rdata_o[m*DATA_WIDTH +: DATA_WIDTH] = Q_scm1;
                end
            end
        end
    end

endmodule

// File: tb/tb_scm_port_arbiter.sv
// Randomized + directed scoreboard bench for scm_port_arbiter with a behavioural SCM macro.
module tb_scm_port_arbiter;

    localparam int NM = 4;
    localparam int AW = 11;
    localparam int DW = 32;

    logic CLK = 1'b0;
    logic RSTN = 1'b0;
    logic [NM-1:0]    req_i = '0;
    logic [NM-1:0]    wen_i = '1;
    logic [NM*AW-1:0] add_i = '0;
    logic [NM*4-1:0]  be_i = '0;
    logic [NM*DW-1:0] wdata_i = '0;
    logic [NM-1:0]    gnt_o;
    logic [NM-1:0]    r_valid_o;
    logic [NM*DW-1:0] r_rdata_o;
    logic CEN, CEN_scm0, CEN_scm1, WEN, WEN_scm0, WEN_scm1;
    logic [3:0]    BE, BE_scm0;
    logic [AW-1:0] A, A_scm0, A_scm1;
    logic [DW-1:0] D, D_scm0;
    logic [DW-1:0] Q, Q_scm0, Q_scm1;

    scm_port_arbiter #(.NB_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .CLK(CLK), .RSTN(RSTN), .req_i(req_i), .gnt_o(gnt_o), .add_i(add_i), .wen_i(wen_i),
        .be_i(be_i), .wdata_i(wdata_i), .r_valid_o(r_valid_o), .r_rdata_o(r_rdata_o),
        .CEN(CEN), .CEN_scm0(CEN_scm0), .CEN_scm1(CEN_scm1),
        .WEN(WEN), .WEN_scm0(WEN_scm0), .WEN_scm1(WEN_scm1),
        .BE(BE), .BE_scm0(BE_scm0), .A(A), .A_scm0(A_scm0), .A_scm1(A_scm1),
        .D(D), .D_scm0(D_scm0), .Q(Q), .Q_scm0(Q_scm0), .Q_scm1(Q_scm1)
    );

    always #5 CLK = ~CLK;

    // Behavioural SCM macro: read data appears the cycle after the access.
    logic [DW-1:0] mem [2048];
    logic [DW-1:0] ref_mem [2048];

    initial begin
        for (int i = 0; i < 2048; i++) begin
            mem[i] <= 32'(i * 32'h9E3779B1) ^ 32'h00C0FFEE;
            ref_mem[i] = 32'(i * 32'h9E3779B1) ^ 32'h00C0FFEE;
        end
        mem[5] <= 32'hDEADBEEF;
        ref_mem[5] = 32'hDEADBEEF;
        Q <= '0;
        Q_scm0 <= '0;
        Q_scm1 <= '0;
    end

    always @(posedge CLK) begin
        if (!CEN && WEN) Q <= mem[A];
        if (!CEN_scm0 && WEN_scm0) Q_scm0 <= mem[A_scm0];
        if (!CEN_scm1) Q_scm1 <= mem[A_scm1];
        for (int b = 0; b < 4; b++) begin
            if (!CEN && !WEN && BE[b]) mem[A][8*b +: 8] <= D[8*b +: 8];
            if (!CEN_scm0 && !WEN_scm0 && BE_scm0[b]) mem[A_scm0][8*b +: 8] <= D_scm0[8*b +: 8];
        end
    end

    int checks = 0;
    int errors = 0;
    int m_rr = 0;
    bit in_reset = 1'b1;

    typedef struct {
        logic [NM-1:0]    v;
        logic [NM*DW-1:0] d;
    } rec_t;
    rec_t sb[$];

    logic [NM-1:0] t_req, t_wen;
    logic [AW-1:0] t_addr [NM];
    logic [3:0]    t_be [NM];
    logic [DW-1:0] t_wd [NM];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_t();
        t_req = '0;
        t_wen = '1;
        for (int m = 0; m < NM; m++) begin
            t_addr[m] = '0;
            t_be[m] = 4'hF;
            t_wd[m] = '0;
        end
    endtask

    // One cycle: drive stimulus, predict grants/ports from the allocation rules, queue the response.
    task automatic drive_cycle();
        logic [NM-1:0] eg;
        int pm[3];
        bit used[3];
        int last, p, m;
        bit hz;
        logic [AW-1:0] wr_q[$];
        logic [AW-1:0] rd_q[$];
        rec_t r;
        logic [110:0] ep, ap;

        @(negedge CLK);
        for (int i = 0; i < NM; i++) begin
            req_i[i] = t_req[i];
            wen_i[i] = t_wen[i];
            add_i[i*AW +: AW] = t_addr[i];
            be_i[i*4 +: 4] = t_be[i];
            wdata_i[i*DW +: DW] = t_wd[i];
        end
        #1;

        eg = '0;
        last = -1;
        for (int i = 0; i < 3; i++) begin
            used[i] = 1'b0;
            pm[i] = 0;
        end
        for (int k = 0; k < NM; k++) begin
            m = (m_rr + k) % NM;
            if (!t_req[m]) continue;
            hz = 1'b0;
            foreach (wr_q[i]) if (wr_q[i] == t_addr[m]) hz = 1'b1;
            if (!t_wen[m]) foreach (rd_q[i]) if (rd_q[i] == t_addr[m]) hz = 1'b1;
            if (hz) continue;
            p = -1;
            if (!t_wen[m]) begin
                if (!used[0]) p = 0;
                else if (!used[1]) p = 1;
            end else begin
                if (!used[2]) p = 2;
                else if (!used[1]) p = 1;
                else if (!used[0]) p = 0;
            end
            if (p < 0) continue;
            used[p] = 1'b1;
            pm[p] = m;
            eg[m] = 1'b1;
            last = m;
            if (t_wen[m]) rd_q.push_back(t_addr[m]);
            else wr_q.push_back(t_addr[m]);
        end
        if (last >= 0) m_rr = (last + 1) % NM;

        ep[110:62] = used[0] ? {1'b0, t_wen[pm[0]], t_be[pm[0]], t_addr[pm[0]], t_wd[pm[0]]} : {2'b11, 47'h0};
        ep[61:13]  = used[1] ? {1'b0, t_wen[pm[1]], t_be[pm[1]], t_addr[pm[1]], t_wd[pm[1]]} : {2'b11, 47'h0};
        ep[12:0]   = used[2] ? {1'b0, t_wen[pm[2]], t_addr[pm[2]]} : {2'b11, 11'h0};
        ap = {CEN, WEN, BE, A, D, CEN_scm0, WEN_scm0, BE_scm0, A_scm0, D_scm0, CEN_scm1, WEN_scm1, A_scm1};
        chk("gnt", 128'(gnt_o), 128'(eg));
        chk("ports", 128'(ap), 128'(ep));

        r.v = eg;
        r.d = '0;
        for (int i = 0; i < NM; i++)
            if (eg[i] && t_wen[i]) r.d[i*DW +: DW] = ref_mem[t_addr[i]];
        for (int i = 0; i < NM; i++)
            if (eg[i] && !t_wen[i])
                for (int b = 0; b < 4; b++)
                    if (t_be[i][b]) ref_mem[t_addr[i]][8*b +: 8] = t_wd[i][8*b +: 8];
        sb.push_back(r);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RSTN = 1'b0;
        in_reset = 1'b1;
        req_i = '0;
        sb.delete();
        m_rr = 0;
        @(negedge CLK);
        RSTN = 1'b1;
        in_reset = 1'b0;
    endtask

    task automatic set_m(input int m, input bit rd, input logic [AW-1:0] a, input logic [DW-1:0] d);
        t_req[m] = 1'b1;
        t_wen[m] = rd;
        t_addr[m] = a;
        t_wd[m] = d;
        t_be[m] = 4'hF;
    endtask

    // Response monitor: one queue entry per driven cycle, compared after the next clock edge.
    initial begin
        rec_t r;
        forever begin
            @(posedge CLK);
            #2;
            if (in_reset || sb.size() == 0) begin
                chk("r_valid_idle", 128'(r_valid_o), 128'(0));
            end else begin
                r = sb.pop_front();
                chk("r_valid", 128'(r_valid_o), 128'(r.v));
                chk("r_rdata", 128'(r_rdata_o), 128'(r.d));
            end
        end
    end

    initial begin
        clear_t();
        repeat (3) @(negedge CLK);
        chk("reset_gnt", 128'(gnt_o), 128'(0));
        chk("reset_cen", 128'({CEN, CEN_scm0, CEN_scm1, WEN, WEN_scm0, WEN_scm1}), 128'(6'b111111));
        chk("reset_rvalid", 128'(r_valid_o), 128'(0));
        RSTN = 1'b1;
        in_reset = 1'b0;

        // Single read from preloaded word.
        clear_t();
        set_m(0, 1'b1, 11'h005, '0);
        drive_cycle();
        chk("single_gnt", 128'(gnt_o), 128'(4'b0001));
        chk("single_a_scm1", 128'({CEN_scm1, A_scm1}), 128'({1'b0, 11'h005}));
        clear_t();
        drive_cycle();

        // Full load from rr=0, then same stimulus from rr=3.
        do_reset();
        clear_t();
        set_m(0, 1'b0, 11'h010, 32'h1111_0000);
        set_m(1, 1'b0, 11'h020, 32'h2222_0000);
        set_m(2, 1'b1, 11'h030, '0);
        set_m(3, 1'b1, 11'h040, '0);
        drive_cycle();
        chk("full_gnt", 128'(gnt_o), 128'(4'b0111));
        chk("full_addrs", 128'({A, A_scm0, A_scm1}), 128'({11'h010, 11'h020, 11'h030}));
        drive_cycle();
        chk("full_rr3_gnt", 128'(gnt_o), 128'(4'b1011));

        // Third write is deferred.
        do_reset();
        clear_t();
        set_m(0, 1'b0, 11'h050, 32'hA0A0_A0A0);
        set_m(1, 1'b0, 11'h051, 32'hA1A1_A1A1);
        set_m(2, 1'b0, 11'h052, 32'hA2A2_A2A2);
        drive_cycle();
        chk("wr3_gnt", 128'(gnt_o), 128'(4'b0011));
        t_req[0] = 1'b0;
        t_req[1] = 1'b0;
        drive_cycle();
        chk("wr3_next_gnt", 128'(gnt_o), 128'(4'b0100));

        // Read-after-write hazard on the same word.
        do_reset();
        clear_t();
        set_m(0, 1'b0, 11'h100, 32'h1234_5678);
        set_m(1, 1'b1, 11'h100, '0);
        drive_cycle();
        chk("hazard_gnt", 128'(gnt_o), 128'(4'b0001));
        t_req[0] = 1'b0;
        drive_cycle();
        chk("hazard_next_gnt", 128'(gnt_o), 128'(4'b0010));
        clear_t();
        drive_cycle();
        chk("hazard_rdata", 128'(r_rdata_o[DW +: DW]), 128'(32'h1234_5678));

        // Same-address reads share the word across all three ports.
        do_reset();
        clear_t();
        set_m(0, 1'b1, 11'h7FF, '0);
        set_m(1, 1'b1, 11'h7FF, '0);
        set_m(2, 1'b1, 11'h7FF, '0);
        drive_cycle();
        chk("same_rd_gnt", 128'(gnt_o), 128'(4'b0111));
        chk("same_rd_addrs", 128'({A, A_scm0, A_scm1}), 128'({11'h7FF, 11'h7FF, 11'h7FF}));

        // Reset while three responses are pending.
        do_reset();
        clear_t();
        set_m(0, 1'b0, 11'h200, 32'hCAFE_0001);
        set_m(1, 1'b1, 11'h201, '0);
        set_m(2, 1'b1, 11'h202, '0);
        drive_cycle();
        chk("rst_pre_gnt", 128'(gnt_o), 128'(4'b0111));
        @(posedge CLK);
        #1;
        RSTN = 1'b0;
        in_reset = 1'b1;
        sb.delete();
        m_rr = 0;
        #1;
        chk("rst_rvalid", 128'(r_valid_o), 128'(0));
        chk("rst_rdata", 128'(r_rdata_o), 128'(0));
        chk("rst_gnt_blocked", 128'(gnt_o), 128'(0));
        chk("rst_cen", 128'({CEN, CEN_scm0, CEN_scm1}), 128'(3'b111));
        @(negedge CLK);
        @(negedge CLK);
        req_i = '0;
        RSTN = 1'b1;
        in_reset = 1'b0;
        drive_cycle();
        chk("rst_post_gnt", 128'(gnt_o), 128'(4'b0111));

        // Random traffic with a narrow address window to provoke hazards.
        for (int c = 0; c < 600; c++) begin
            for (int m = 0; m < NM; m++) begin
                t_req[m] = 1'($urandom_range(0, 3) != 0);
                t_wen[m] = 1'($urandom_range(0, 1));
                t_addr[m] = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
                t_be[m] = 4'($urandom);
                t_wd[m] = $urandom;
            end
            drive_cycle();
        end

        clear_t();
        drive_cycle();
        drive_cycle();
        @(negedge CLK);
        chk("scoreboard_drained", 128'(sb.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
